// File: rtl/mul_share_if.sv
// Requester-side bundle of the shared multiplier arbiter: operand requests in, grants and products out.
// master = requester side, slave = arbiter side.
interface mul_share_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] a_in;
  logic [32*NREQ-1:0] b_in;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [63:0]        rsp_data;

  modport master (output req, a_in, b_in, input gnt, rsp_valid, rsp_data);
  modport slave  (input req, a_in, b_in, output gnt, rsp_valid, rsp_data);
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one LAT-deep pipelined multiplier; grant is same-cycle, product returns LAT cycles later.
// No backpressure: one issue per cycle, requesters must take rsp_valid unconditionally.
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int TAGW = 2,
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  mul_share_if.slave    rq,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  input  logic [63:0]   mul_p,
  output logic [CW-1:0] inflight,
  output logic          busy
);

  logic [TAGW-1:0] prio;
  logic            gnt_any;
  logic [TAGW-1:0] gnt_idx;
  int              cand;
  logic [NREQ-1:0] gnt_oh;

  logic [LAT-1:0]  vld_pipe;
  logic [TAGW-1:0] tag_pipe [LAT];
  logic            retire;
  logic [NREQ-1:0] rsp_oh;

  // Search from prio upward, wrapping; the first hit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (en && rst) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(prio) + k;
        if (cand >= NREQ) cand = cand - NREQ;
        if (!gnt_any && rq.req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = TAGW'(cand);
        end
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    mul_a  = '0;
    mul_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_any && gnt_idx == TAGW'(i)) begin
        gnt_oh[i] = 1'b1;
        mul_a     = rq.a_in[32*i +: 32];
        mul_b     = rq.b_in[32*i +: 32];
      end
    end
  end

  assign rq.gnt = gnt_oh;
  assign retire = vld_pipe[LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio     <= '0;
      vld_pipe <= '0;
      inflight <= '0;
      for (int k = 0; k < LAT; k++) tag_pipe[k] <= '0;
    end else begin
      if (gnt_any) begin
        if (int'(gnt_idx) == NREQ - 1) prio <= '0;
        else                           prio <= gnt_idx + 1'b1;
      end
      // Tag travels in lockstep with the operands through the multiplier.
      vld_pipe[0] <= gnt_any;
      tag_pipe[0] <= gnt_idx;
      for (int k = 1; k < LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
      if (gnt_any && !retire)      inflight <= inflight + 1'b1;
      else if (!gnt_any && retire) inflight <= inflight - 1'b1;
    end
  end

  always_comb begin
    rsp_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (retire && tag_pipe[LAT-1] == TAGW'(i)) rsp_oh[i] = 1'b1;
    end
  end

  assign rq.rsp_valid = rsp_oh;
  assign rq.rsp_data  = retire ? mul_p : 64'd0;
  assign busy         = (inflight != '0);

endmodule
